// File: rtl/mips_main_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional macro LOGIC_IMM_EN adds the LOGEX state for andi/ori (zero-extended immediates).
module mips_main_controller #(
    parameter int OP_WIDTH    = 6,
    parameter int STATE_WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [OP_WIDTH-1:0]    Op,
    input  logic                   Zero,
    output logic                   IorD,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             ALUOp,
    output logic [1:0]             PCSrc,
    output logic                   PCEn,
    output logic                   s_notz,
    output logic                   illegal_op,
    output logic [STATE_WIDTH-1:0] state_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_IMMWB, S_JUMP, S_LOGEX
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_ANDI  = OP_WIDTH'(6'b001100);
    localparam logic [OP_WIDTH-1:0] OP_ORI   = OP_WIDTH'(6'b001101);
    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   op_legal;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
            S_EXECUTE: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1; end
            S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_IMMWB:   c.reg_write = 1'b1;
            S_JUMP:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
`ifdef LOGIC_IMM_EN
            S_LOGEX:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
`endif
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d  = S_FETCH;
        op_legal = 1'b1;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW) state_d = S_MEMADR;
                else if (Op == OP_RTYPE)        state_d = S_EXECUTE;
                else if (Op == OP_BEQ)          state_d = S_BRANCH;
                else if (Op == OP_ADDI)         state_d = S_ADDIEX;
                else if (Op == OP_J)            state_d = S_JUMP;
`ifdef LOGIC_IMM_EN
                else if (Op == OP_ANDI || Op == OP_ORI) state_d = S_LOGEX;
`endif
                else                            op_legal = 1'b0;
            end
            S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_IMMWB;
`ifdef LOGIC_IMM_EN
            S_LOGEX:   state_d = S_IMMWB;
`endif
            default:   state_d = S_FETCH;
        endcase
        // outputs are registered alongside the state so they stay a pure function of it
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign IorD       = ctrl_q.iord;
    assign MemWrite   = ctrl_q.mem_write;
    assign IRWrite    = ctrl_q.ir_write;
    assign RegDst     = ctrl_q.reg_dst;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign RegWrite   = ctrl_q.reg_write;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ALUOp      = ctrl_q.alu_op;
    assign PCSrc      = ctrl_q.pc_src;
    assign PCEn       = ctrl_q.pc_write | (ctrl_q.branch & Zero);
    assign illegal_op = (state_q == S_DECODE) && !op_legal;
    assign state_o    = STATE_WIDTH'(state_q);
`ifdef LOGIC_IMM_EN
    assign s_notz     = (state_q != S_LOGEX);
`else
    assign s_notz     = 1'b1;
`endif
endmodule
